// File: rtl/bytes_to_bridge_pkg.sv
// Shared bridge definitions: read-engine state encoding and the big-endian
// lane order used by both the byte writer and the byte reader.
package bytes_to_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } rd_state_e;

  // Lane 0 is the most significant byte: 0->24, 1->16, 2->8, 3->0.
  function automatic logic [4:0] lane_to_bits(input logic [1:0] lane);
    return {~lane, 3'b000};
  endfunction

endpackage

// File: rtl/bytes_to_bridge.sv
// Answers 32-bit bridge reads by fetching four consecutive bytes from the
// byte-wide core memory port and returning them as one big-endian word.
//
// state   | meaning
// IDLE    | waiting for bridge read, base address latched on acceptance
// ISSUE   | holding off until strobe spacing is met, then strobe mem.rd
// WAIT    | waiting for the byte of the current lane or its timeout
// RESPOND | presenting the assembled word to the bridge
module bytes_to_bridge
  import bytes_to_bridge_pkg::*;
#(
  parameter int CYCLES  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_bridge_addr,
  input  logic        i_bridge_rd,
  output logic [31:0] o_bridge_rd_data,
  output logic        o_bridge_rd_data_valid,
  output logic [24:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rd_data,
  input  logic        i_mem_rd_data_valid,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_timed_out
);

  localparam int CMAX = (CYCLES > TIMEOUT) ? CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] CYC_T   = CW'(CYCLES);
  localparam logic [CW-1:0] TO_T    = CW'(TIMEOUT);

  rd_state_e    r_state;
  rd_state_e    w_next;
  logic [24:0]  r_base;
  logic [1:0]   r_lane;
  logic [CW-1:0] r_cnt;
  logic         r_first;
  logic [31:0]  r_word;
  logic [31:0]  r_rd_data;
  logic         r_rd_valid;
  logic [24:0]  r_mem_addr;
  logic         r_busy;
  logic         r_overrun;
  logic         r_timed_out;

  logic w_accept;
  logic w_space_ok;
  logic w_strobe;
  logic w_byte_ok;
  logic w_expire;
  logic w_lane_done;
  logic w_unused_addr;

  assign w_unused_addr = &{1'b0, i_bridge_addr[31:25], i_bridge_addr[1:0]};

  assign w_accept    = (r_state == ST_IDLE) && i_bridge_rd;
  assign w_space_ok  = r_first || (r_cnt >= CYC_T);
  assign w_strobe    = (r_state == ST_ISSUE) && w_space_ok;
  assign w_byte_ok   = (r_state == ST_WAIT) && i_mem_rd_data_valid;
  // A byte arriving on the expiry cycle is still taken.
  assign w_expire    = (r_state == ST_WAIT) && !i_mem_rd_data_valid && (r_cnt == TO_T);
  assign w_lane_done = w_byte_ok || w_expire;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_bridge_rd) w_next = ST_ISSUE;
      ST_ISSUE:   if (w_space_ok) w_next = ST_WAIT;
      ST_WAIT:    if (w_lane_done) w_next = (r_lane == 2'd3) ? ST_RESPOND : ST_ISSUE;
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // One counter counts cycles since the last strobe; it serves both the
  // strobe spacing check and the byte timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      if (w_strobe) begin
        r_cnt <= CW'(1);
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_first <= 1'b1;
      end else if (w_strobe) begin
        r_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base     <= '0;
      r_lane     <= '0;
      r_mem_addr <= '0;
      r_word     <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= {i_bridge_addr[24:2], 2'b00};
        r_lane     <= 2'd0;
        r_mem_addr <= {i_bridge_addr[24:2], 2'b00};
      end
      if (w_lane_done) begin
        r_word[lane_to_bits(r_lane) +: 8] <= w_byte_ok ? i_mem_rd_data : 8'hFF;
        if (r_lane != 2'd3) begin
          r_lane     <= r_lane + 2'd1;
          r_mem_addr <= r_base + {23'd0, r_lane + 2'd1};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_rd_valid  <= (r_state == ST_RESPOND);
      if (r_state == ST_RESPOND) begin
        r_rd_data <= r_word;
      end
      r_busy      <= (r_state != ST_IDLE) || w_accept;
      r_overrun   <= i_bridge_rd && (r_state != ST_IDLE);
      r_timed_out <= w_expire;
    end
  end

  assign o_bridge_rd_data       = r_rd_data;
  assign o_bridge_rd_data_valid = r_rd_valid;
  assign o_mem_addr             = r_mem_addr;
  assign o_mem_rd               = w_strobe;
  assign o_mem_wr               = 1'b0;
  assign o_busy                 = r_busy;
  assign o_overrun              = r_overrun;
  assign o_timed_out            = r_timed_out;

endmodule

// File: tb/tb_bytes_to_bridge.sv
// Scoreboard bench for bytes_to_bridge: two instances (CYCLES=8/TIMEOUT=10 and
// CYCLES=1/TIMEOUT=255), each with a latency-modelled byte memory.
module tb_bytes_to_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] mem_bytes [int];
  function automatic logic [7:0] byte_at(input logic [24:0] a);
    if (mem_bytes.exists(int'(a))) return mem_bytes[int'(a)];
    return 8'h00;
  endfunction

  typedef struct { int due; logic [24:0] addr; } pend_t;
  typedef struct { logic [31:0] word; int lat; } resp_t;

  // ---------------- instance A ----------------
  logic [31:0] a_baddr = '0;
  logic        a_brd = 1'b0;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic [24:0] a_maddr;
  logic        a_mrd, a_mwr;
  logic [7:0]  a_mdata = '0;
  logic        a_mvalid = 1'b0;
  logic        a_busy, a_ovr, a_to;

  bytes_to_bridge #(.CYCLES(8), .TIMEOUT(10)) dut_a (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_bridge_addr(a_baddr), .i_bridge_rd(a_brd),
    .o_bridge_rd_data(a_rdata), .o_bridge_rd_data_valid(a_rvalid),
    .o_mem_addr(a_maddr), .o_mem_rd(a_mrd), .o_mem_wr(a_mwr),
    .i_mem_rd_data(a_mdata), .i_mem_rd_data_valid(a_mvalid),
    .o_busy(a_busy), .o_overrun(a_ovr), .o_timed_out(a_to)
  );

  // ---------------- instance B ----------------
  logic [31:0] b_baddr = '0;
  logic        b_brd = 1'b0;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic [24:0] b_maddr;
  logic        b_mrd, b_mwr;
  logic [7:0]  b_mdata = '0;
  logic        b_mvalid = 1'b0;
  logic        b_busy, b_ovr, b_to;

  bytes_to_bridge #(.CYCLES(1), .TIMEOUT(255)) dut_b (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_bridge_addr(b_baddr), .i_bridge_rd(b_brd),
    .o_bridge_rd_data(b_rdata), .o_bridge_rd_data_valid(b_rvalid),
    .o_mem_addr(b_maddr), .o_mem_rd(b_mrd), .o_mem_wr(b_mwr),
    .i_mem_rd_data(b_mdata), .i_mem_rd_data_valid(b_mvalid),
    .o_busy(b_busy), .o_overrun(b_ovr), .o_timed_out(b_to)
  );

  // Memory models: a strobe seen at negedge c lands on edge c+1; the byte is
  // driven from negedge c+L so it is sampled on edge c+1+L.
  int    lat_a = 2;
  int    slow_addr_a = -1;
  int    slow_lat_a = 0;
  pend_t pend_a[$];
  always @(negedge clk) begin : mem_model_a
    pend_t keep[$];
    keep = {};
    a_mvalid = 1'b0;
    foreach (pend_a[i]) begin
      if (pend_a[i].due == cyc) begin
        a_mvalid = 1'b1;
        a_mdata  = byte_at(pend_a[i].addr);
      end else begin
        keep.push_back(pend_a[i]);
      end
    end
    pend_a = keep;
    if (a_mrd) begin
      if (int'(a_maddr) == slow_addr_a) pend_a.push_back('{due: cyc + slow_lat_a, addr: a_maddr});
      else pend_a.push_back('{due: cyc + lat_a, addr: a_maddr});
    end
  end

  int    lat_b = 20;
  pend_t pend_b[$];
  always @(negedge clk) begin : mem_model_b
    pend_t keep[$];
    keep = {};
    b_mvalid = 1'b0;
    foreach (pend_b[i]) begin
      if (pend_b[i].due == cyc) begin
        b_mvalid = 1'b1;
        b_mdata  = byte_at(pend_b[i].addr);
      end else begin
        keep.push_back(pend_b[i]);
      end
    end
    pend_b = keep;
    if (b_mrd) pend_b.push_back('{due: cyc + lat_b, addr: b_maddr});
  end

  // Scoreboard queues
  logic [24:0] exp_addr_a[$];
  int          exp_gap_a[$];
  resp_t       exp_resp_a[$];
  logic [24:0] exp_addr_b[$];
  int          exp_gap_b[$];
  resp_t       exp_resp_b[$];
  int req_edge_a = 0, req_edge_b = 0;
  int last_strobe_a = 0, last_strobe_b = 0;
  int resp_cnt_a = 0, resp_cnt_b = 0, strobe_cnt_a = 0;
  int ovr_cnt_a = 0, to_cnt_a = 0;

  always @(negedge clk) begin : strobe_mon_a
    int g;
    if (a_mrd) begin
      strobe_cnt_a++;
      if (exp_addr_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL strobe_a_unexpected: got addr %h, expected no strobe", a_maddr);
      end else begin
        check("mem_addr_a", 32'(a_maddr), 32'(exp_addr_a.pop_front()));
        g = exp_gap_a.pop_front();
        if (g != 0) check("strobe_gap_a", 32'(cyc + 1 - last_strobe_a), 32'(g));
      end
      last_strobe_a = cyc + 1;
    end
    if (a_ovr) ovr_cnt_a++;
    if (a_to)  to_cnt_a++;
  end

  always @(negedge clk) begin : resp_mon_a
    resp_t r;
    if (a_rvalid) begin
      resp_cnt_a++;
      if (exp_resp_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL resp_a_unexpected: got %h, expected no response", a_rdata);
      end else begin
        r = exp_resp_a.pop_front();
        check("rd_data_a", a_rdata, r.word);
        check("latency_a", 32'(cyc + 1 - req_edge_a), 32'(r.lat));
        check("busy_at_resp_a", 32'(a_busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    resp_t r;
    int g;
    if (b_mrd) begin
      if (exp_addr_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL strobe_b_unexpected: got addr %h, expected no strobe", b_maddr);
      end else begin
        check("mem_addr_b", 32'(b_maddr), 32'(exp_addr_b.pop_front()));
        g = exp_gap_b.pop_front();
        if (g != 0) check("strobe_gap_b", 32'(cyc + 1 - last_strobe_b), 32'(g));
      end
      last_strobe_b = cyc + 1;
    end
    if (b_rvalid) begin
      resp_cnt_b++;
      if (exp_resp_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL resp_b_unexpected: got %h, expected no response", b_rdata);
      end else begin
        r = exp_resp_b.pop_front();
        check("rd_data_b", b_rdata, r.word);
        check("latency_b", 32'(cyc + 1 - req_edge_b), 32'(r.lat));
      end
    end
  end

  task automatic expect_a(input logic [24:0] base, input logic [31:0] word, input int lat,
                          input int g1, input int g2, input int g3);
    exp_addr_a.push_back(base);         exp_gap_a.push_back(0);
    exp_addr_a.push_back(base + 25'd1); exp_gap_a.push_back(g1);
    exp_addr_a.push_back(base + 25'd2); exp_gap_a.push_back(g2);
    exp_addr_a.push_back(base + 25'd3); exp_gap_a.push_back(g3);
    exp_resp_a.push_back('{word: word, lat: lat});
  endtask

  task automatic issue_a(input logic [31:0] addr);
    @(negedge clk);
    a_baddr = addr; a_brd = 1'b1;
    req_edge_a = cyc + 1;
    @(negedge clk);
    a_brd = 1'b0;
  endtask

  task automatic wait_resp_a(input int target);
    int t = 0;
    while (resp_cnt_a < target && t < 400) begin
      @(posedge clk); t++;
    end
    check("resp_arrived_a", 32'(resp_cnt_a), 32'(target));
    @(negedge clk);
    check("busy_low_a", 32'(a_busy), 32'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_rd_data"},  a_rdata, 32'd0);
    check({tag, "_rvalid"},   32'(a_rvalid), 32'd0);
    check({tag, "_mem_addr"}, 32'(a_maddr), 32'd0);
    check({tag, "_mem_rd"},   32'(a_mrd), 32'd0);
    check({tag, "_mem_wr"},   32'(a_mwr), 32'd0);
    check({tag, "_busy"},     32'(a_busy), 32'd0);
    check({tag, "_overrun"},  32'(a_ovr), 32'd0);
    check({tag, "_timedout"}, 32'(a_to), 32'd0);
  endtask

  initial begin
    int t, ov0, to0, rc0;
    mem_bytes[32'h100] = 8'h12; mem_bytes[32'h101] = 8'h34;
    mem_bytes[32'h102] = 8'h56; mem_bytes[32'h103] = 8'h78;
    mem_bytes[32'h300] = 8'h9A; mem_bytes[32'h301] = 8'hBC;
    mem_bytes[32'h302] = 8'hDE; mem_bytes[32'h303] = 8'hF0;
    mem_bytes[32'h400] = 8'hAA; mem_bytes[32'h401] = 8'hBB;
    mem_bytes[32'h402] = 8'hCC; mem_bytes[32'h403] = 8'hDD;
    mem_bytes[32'h1FFFFFC] = 8'hA1; mem_bytes[32'h1FFFFFD] = 8'hB2;
    mem_bytes[32'h1FFFFFE] = 8'hC3; mem_bytes[32'h1FFFFFF] = 8'hD4;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("reset_a");
    check("reset_b_rd_data", b_rdata, 32'd0);
    check("reset_b_busy", 32'(b_busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency 2, CYCLES 8: strobes 8 apart, latency 1+3*8+2+2.
    expect_a(25'h100, 32'h12345678, 29, 8, 8, 8);
    issue_a(32'h0000_0100);
    wait_resp_a(1);

    // Upper and low address bits ignored.
    expect_a(25'h100, 32'h12345678, 29, 8, 8, 8);
    issue_a(32'hF000_0103);
    wait_resp_a(2);

    // Lane 2 answers only after timeout, while lane 3 is being issued.
    slow_addr_a = 32'h402; slow_lat_a = 11;
    to0 = to_cnt_a;
    expect_a(25'h400, 32'hAABBFFDD, 32, 8, 8, 11);
    issue_a(32'h0000_0400);
    wait_resp_a(3);
    check("timed_out_pulses", 32'(to_cnt_a - to0), 32'd1);
    slow_addr_a = -1;

    // Second request 3 cycles after the first is dropped.
    ov0 = ovr_cnt_a;
    expect_a(25'h100, 32'h12345678, 29, 8, 8, 8);
    issue_a(32'h0000_0100);
    repeat (2) @(negedge clk);
    a_baddr = 32'h0000_0300; a_brd = 1'b1;
    @(negedge clk);
    a_brd = 1'b0;
    wait_resp_a(4);
    check("overrun_pulses", 32'(ov0 + 1 - ovr_cnt_a), 32'd0);
    repeat (5) @(negedge clk);
    check("single_response", 32'(resp_cnt_a), 32'd4);

    // Reset during WAIT of lane 1.
    exp_addr_a.push_back(25'h100); exp_gap_a.push_back(0);
    exp_addr_a.push_back(25'h101); exp_gap_a.push_back(8);
    rc0 = strobe_cnt_a;
    issue_a(32'h0000_0100);
    t = 0;
    while (strobe_cnt_a < rc0 + 2 && t < 100) begin
      @(posedge clk); t++;
    end
    check("lane1_strobe_seen", 32'(strobe_cnt_a), 32'(rc0 + 2));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_a("midreset_a");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_resp_after_reset", 32'(resp_cnt_a), 32'd4);
    check("addr_q_after_reset", 32'(exp_addr_a.size()), 32'd0);
    expect_a(25'h100, 32'h12345678, 29, 8, 8, 8);
    issue_a(32'h0000_0100);
    wait_resp_a(5);

    // Instance B: top of memory, latency 20, CYCLES 1 -> gaps of 21.
    exp_addr_b.push_back(25'h1FFFFFC); exp_gap_b.push_back(0);
    exp_addr_b.push_back(25'h1FFFFFD); exp_gap_b.push_back(21);
    exp_addr_b.push_back(25'h1FFFFFE); exp_gap_b.push_back(21);
    exp_addr_b.push_back(25'h1FFFFFF); exp_gap_b.push_back(21);
    exp_resp_b.push_back('{word: 32'hA1B2C3D4, lat: 86});
    @(negedge clk);
    b_baddr = 32'h01FF_FFFC; b_brd = 1'b1;
    req_edge_b = cyc + 1;
    @(negedge clk);
    b_brd = 1'b0;
    t = 0;
    while (resp_cnt_b < 1 && t < 400) begin
      @(posedge clk); t++;
    end
    check("resp_arrived_b", 32'(resp_cnt_b), 32'd1);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_resp_a.size() + exp_resp_b.size() + exp_addr_b.size()), 32'd0);
    check("mem_wr_held_low", 32'(a_mwr | b_mwr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/bytes_to_bridge.md
# bytes_to_bridge

Read-side companion to the bridge byte-writer. Answers 32-bit bridge read requests by fetching four consecutive bytes from a byte-wide core memory port and returning one big-endian word. It sits after the bridge CDC in the core clock domain and shares the byte memory port with the writer through an external arbiter. It allows the APF host to read back loaded ROM/RAM and core state.

## Interface
- `CYCLES`, default 8: minimum cycles between successive `mem.rd` strobes (≥1).
- `TIMEOUT`, default 255: cycles to wait for a byte before abandoning it (≥1).
- `clk` in, 1: core clock. Both bus_if instances are clocked by it.
- `reset_n` in, 1: asynchronous, active-low reset.
- `bridge` bus_if, responder side, addr_width 32, data_width 32: uses `addr`, `rd`, `rd_data`, `rd_data_valid`. `wr` is ignored.
- `mem` bus_if, initiator side, addr_width 25, data_width 8: drives `addr` and `rd`, samples `rd_data` and `rd_data_valid`. `wr` is held 0.
- `busy` out, 1: high from request acceptance until the response pulse, inclusive.
- `overrun` out, 1: one-cycle pulse when a `bridge.rd` is dropped.
- `timed_out` out, 1: one-cycle pulse per byte abandoned on timeout.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: when `bridge.rd` is high, latch the base address as `bridge.addr[24:2]` with 2'b00 appended, clear the lane index to 0, and go to ISSUE. Address bits [1:0] are ignored and bits [31:25] are discarded.
- ISSUE:
  - Stay until the spacing counter reaches `CYCLES` since the previous strobe. The first strobe of a request waits for nothing.
  - Then pulse `mem.rd` for one cycle with `mem.addr` = base + lane, load the timeout counter, and go to WAIT.
- WAIT:
  - On `mem.rd_data_valid`, write `mem.rd_data` into the lane. Lane 0 goes to bits [31:24] and lane 3 to bits [7:0].
  - On timeout expiry, write 8'hFF into the lane and pulse `timed_out`.
  - If lane = 3, go to RESPOND. Otherwise increment the lane and go to ISSUE.
- RESPOND: drive `bridge.rd_data` with the assembled word, pulse `bridge.rd_data_valid` for one cycle, and go to IDLE.
- `bridge.rd_data` holds the last response until the next RESPOND.
- A `bridge.rd` in any state other than IDLE is dropped and pulses `overrun`. The in-flight request is unaffected.
- A `mem.rd_data_valid` outside WAIT is ignored. This covers late bytes arriving after a timeout.
- Lane address wraps modulo 2^25 at the top of memory.
- Reset mid-operation: return to IDLE immediately. No response is emitted for the in-flight request.

## Timing
- Reset values:
  - state IDLE
  - `mem.rd`, `mem.wr`, `bridge.rd_data_valid`, `busy`, `overrun`, `timed_out` = 0
  - `mem.addr` = 0
  - `bridge.rd_data` = 0
- Request sampled at cycle 0. First `mem.rd` is at cycle 1.
- Each subsequent `mem.rd` occurs at max(valid cycle + 1, previous strobe + `CYCLES`).
- `bridge.rd_data_valid` occurs 2 cycles after the lane-3 valid, or 2 cycles after the lane-3 timeout.
- With fixed memory latency L (L ≥ 1, valid at strobe + L), total latency = 1 + 3·max(L + 1, CYCLES) + L + 2.
- Timeout fires when `TIMEOUT` cycles pass after the strobe with no valid. If valid and expiry land on the same cycle, valid wins.
- `busy` is registered. It rises the cycle after acceptance and falls the cycle after the response pulse.

## Structure
- The state enum and a `lane_to_bits(lane)` function (lane → bit offset, big-endian) belong in the shared bridge package. The writer uses the same lane order.
- No sub-module. The spacing counter and timeout counter are inline; they can share one counter, since only one of them runs at a time.

## Test plan
- Memory latency 2, `CYCLES`=8, bytes 12 34 56 78 at 0x100, read 0x100 → `rd_data` = 32'h12345678, with `mem.rd` strobes exactly 8 cycles apart.
- Read `bridge.addr` 32'hF000_0103 → `mem.addr` sequence 0x100, 0x101, 0x102, 0x103. Upper address bits are ignored.
- Read at 0x1FF_FFFC with latency 20, `CYCLES`=1 → strobes spaced 21 apart (L+1), and the address sequence ends at 0x1FF_FFFF without wrapping.
- Memory never answers lane 2, `TIMEOUT`=10 → one `timed_out` pulse and `rd_data` = 32'hAABBFFDD. A late lane-2 valid is ignored.
- Second `bridge.rd` issued 3 cycles after the first → one `overrun` pulse and exactly one response, carrying the first address's data.
- `reset_n` asserted during WAIT of lane 1 → all outputs return to reset values and no `rd_data_valid` is emitted. The next read completes normally.
